// File: rtl/mem_loader.sv
// Frame decoder: turns CMD/START/LEN/payload byte frames into memory write pulses,
// or streams memory bytes back out over a valid/ready handshake.
//   state    | meaning
//   IDLE     | waiting for a CMD byte
//   GET_ADDR | waiting for the START byte
//   GET_LEN  | waiting for LEN; range-checks the burst
//   WRITE    | each received byte becomes one mem_we pulse
//   READ     | presenting memory bytes on tx_byte until LEN are accepted
//   DRAIN    | error; ignore bytes until the frame ends
module mem_loader #(
  parameter int DEPTH  = 101,
  parameter int ADDR_W = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_valid,
  input  logic                 frame_active,
  input  logic [DEPTH*8-1:0]   mem_bus,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_data,
  output logic                 mem_we,
  output logic [7:0]           tx_byte,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_LEN, S_WRITE, S_READ, S_DRAIN
  } state_t;

  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                is_rd_q, is_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_data_q, mem_data_d;
  logic                mem_we_q, mem_we_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   rd_idx;
  logic [7:0]          rd_byte;
  logic [8:0]          span;

  // Byte mux over the flattened bus; indices at or above DEPTH read as zero.
  always_comb begin
    rd_byte = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ADDR_W'(k) == rd_idx) rd_byte = mem_bus[k*8 +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    is_rd_d    = is_rd_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    err_d      = err_q;
    rd_idx     = addr_q;
    span       = 9'(addr_q) + 9'(rx_byte);

    if (!frame_active) begin
      // Abort takes priority over any byte arriving in the same cycle.
      state_d    = S_IDLE;
      tx_valid_d = 1'b0;
      addr_d     = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            if (rx_byte == 8'h01 || rx_byte == 8'h02) begin
              is_rd_d = (rx_byte == 8'h02);
              err_d   = 1'b0;
              state_d = S_GET_ADDR;
            end else begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end
        end
        S_GET_ADDR: begin
          if (rx_valid) begin
            addr_d  = rx_byte[ADDR_W-1:0];
            state_d = S_GET_LEN;
          end
        end
        S_GET_LEN: begin
          if (rx_valid) begin
            cnt_d = rx_byte;
            if (rx_byte == 8'd0) begin
              state_d = S_IDLE;
            end else if (span > DEPTH9) begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end else if (is_rd_q) begin
              tx_byte_d  = rd_byte;
              tx_valid_d = 1'b1;
              state_d    = S_READ;
            end else begin
              state_d = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (rx_valid) begin
            mem_addr_d = addr_q;
            mem_data_d = rx_byte;
            mem_we_d   = 1'b1;
            addr_d     = addr_q + ADDR_W'(1);
            cnt_d      = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = S_IDLE;
          end
        end
        S_READ: begin
          if (tx_valid_q && tx_ready) begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              tx_valid_d = 1'b0;
              state_d    = S_IDLE;
            end else begin
              rd_idx    = addr_q + ADDR_W'(1);
              tx_byte_d = rd_byte;
            end
          end
        end
        S_DRAIN: ;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      is_rd_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      is_rd_q    <= is_rd_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;
  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a frame-level model predicts writes, readback bytes
// and the error flag; a negedge monitor checks every write pulse and handshake.
module tb_mem_loader;

  localparam int DEPTH  = 101;
  localparam int ADDR_W = 7;

  typedef logic [7:0] bq_t [$];

  logic                clk;
  logic                reset;
  logic [7:0]          rx_byte;
  logic                rx_valid;
  logic                frame_active;
  logic [DEPTH*8-1:0]  mem_bus;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          mem_data;
  logic                mem_we;
  logic [7:0]          tx_byte;
  logic                tx_valid;
  logic                tx_ready;
  logic                busy;
  logic                err;

  mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_active(frame_active), .mem_bus(mem_bus), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem_img [DEPTH];
  logic [14:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic        exp_err;
  int          n_checks;
  int          n_fail;
  int          hs_count;
  logic        stall_prev;
  logic [7:0]  stall_byte;
  bq_t         fr;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) mem_bus[k*8 +: 8] = mem_img[k];
  end

  // The parameter memory itself: captures each write pulse on the following edge.
  always @(posedge clk) begin
    if (!reset && mem_we && int'(mem_addr) < DEPTH) mem_img[mem_addr] <= mem_data;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: decodes a whole frame's bytes into expected effects.
  task automatic model_frame(input bq_t f);
    int pos = 0;
    int start;
    int len;
    while (pos < f.size()) begin
      if (f[pos] != 8'h01 && f[pos] != 8'h02) begin
        exp_err = 1'b1;
        return;
      end
      exp_err = 1'b0;
      if (pos + 2 >= f.size()) return;
      start = int'(f[pos+1]) % 128;
      len   = int'(f[pos+2]);
      if (len != 0 && start + len > DEPTH) begin
        exp_err = 1'b1;
        return;
      end
      if (f[pos] == 8'h02) begin
        for (int i = 0; i < len; i++) exp_rd.push_back(mem_img[start+i]);
        return;
      end
      pos += 3;
      for (int i = 0; i < len && pos < f.size(); i++) begin
        exp_wr.push_back({7'(start + i), f[pos]});
        pos++;
      end
    end
  endtask

  task automatic send_bytes(input bq_t f, input bit b2b);
    for (int i = 0; i < f.size(); i++) begin
      rx_byte  = f[i];
      rx_valid = 1'b1;
      @(posedge clk); #1;
      if (!b2b) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic frame_end();
    frame_active = 1'b0;
    @(posedge clk); #1;
    frame_active = 1'b1;
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (busy && c < maxc) begin
      @(posedge clk); #1;
      c++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  task automatic end_test(input string nm);
    check({nm, "_err"}, err, exp_err);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_wr_left"}, exp_wr.size(), 0);
    check({nm, "_rd_left"}, exp_rd.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (mem_we) begin
        check("we_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          check("we_addr", mem_addr, exp_wr[0][14:8]);
          check("we_data", mem_data, exp_wr[0][7:0]);
          void'(exp_wr.pop_front());
        end
      end
      if (tx_valid && tx_ready) begin
        hs_count++;
        check("tx_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) check("tx_byte", tx_byte, exp_rd.pop_front());
      end
      if (tx_valid && !tx_ready) begin
        if (stall_prev) check("tx_stable", tx_byte, stall_byte);
        stall_prev = 1'b1;
        stall_byte = tx_byte;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; hs_count = 0; stall_prev = 1'b0; stall_byte = '0;
    exp_err = 1'b0;
    for (int k = 0; k < DEPTH; k++) mem_img[k] = 8'(k * 5 + 3);
    mem_img[99]  = 8'h11;
    mem_img[100] = 8'h22;
    reset = 1'b1; rx_byte = '0; rx_valid = 1'b0; frame_active = 1'b0; tx_ready = 1'b0;

    #12;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    frame_active = 1'b1;
    @(posedge clk); #1;

    // Write burst with one-cycle write latency
    fr = '{8'h01, 8'h05, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    model_frame(fr);
    fr = '{8'h01, 8'h05, 8'h03};
    send_bytes(fr, 1'b0);
    check("wr_busy_mid", busy, 1);
    rx_byte = 8'hAA; rx_valid = 1'b1;
    @(posedge clk); #1;
    check("wr_first_we", mem_we, 1);
    check("wr_first_addr", mem_addr, 5);
    check("wr_first_data", mem_data, 8'hAA);
    rx_byte = 8'hBB;
    @(posedge clk); #1;
    rx_byte = 8'hCC;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("wr_last_addr", mem_addr, 7);
    check("wr_last_data", mem_data, 8'hCC);
    @(posedge clk); #1;
    check("wr_we_done", mem_we, 0);
    check("wr_mem6", mem_img[6], 8'hBB);
    end_test("write");
    frame_end();

    // Read at the top boundary with backpressure
    hs_count = 0;
    fr = '{8'h02, 8'd99, 8'h02};
    model_frame(fr);
    send_bytes(fr, 1'b1);
    check("rd_first_valid", tx_valid, 1);
    check("rd_first_byte", tx_byte, 8'h11);
    repeat (3) begin @(posedge clk); #1; end
    tx_ready = 1'b1;
    wait_idle(20);
    tx_ready = 1'b0;
    check("rd_handshakes", hs_count, 2);
    check("rd_valid_off", tx_valid, 0);
    end_test("read_bp");
    frame_end();

    // Read with ready held high: one byte per cycle
    hs_count = 0;
    tx_ready = 1'b1;
    fr = '{8'h02, 8'h0A, 8'h04};
    model_frame(fr);
    send_bytes(fr, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    check("rd_stream_busy", busy, 0);
    check("rd_stream_hs", hs_count, 4);
    tx_ready = 1'b0;
    end_test("read_stream");
    frame_end();

    // Range error, drained bytes, then a valid LEN 0 command clears err
    fr = '{8'h01, 8'd100, 8'h02, 8'h55, 8'h66};
    model_frame(fr);
    send_bytes(fr, 1'b0);
    check("range_err", err, 1);
    check("range_drain_busy", busy, 1);
    frame_end();
    end_test("range");
    fr = '{8'h02, 8'h00, 8'h00};
    model_frame(fr);
    send_bytes(fr, 1'b1);
    check("len0_err_cleared", err, 0);
    end_test("len0");
    frame_end();

    // Bad command, then a following 0x01 is drained until the frame ends
    fr = '{8'h7F, 8'h01};
    model_frame(fr);
    send_bytes(fr, 1'b1);
    check("badcmd_err", err, 1);
    check("badcmd_drain", busy, 1);
    frame_end();
    check("badcmd_idle", busy, 0);
    check("badcmd_err_kept", err, 1);
    fr = '{8'h01};
    model_frame(fr);
    send_bytes(fr, 1'b1);
    check("newcmd_busy", busy, 1);
    check("newcmd_err", err, 0);
    frame_end();
    end_test("badcmd");

    // Abort mid-write; a byte coinciding with the abort is dropped
    fr = '{8'h01, 8'h00, 8'h0A, 8'h10, 8'h20, 8'h30, 8'h40};
    model_frame(fr);
    send_bytes(fr, 1'b1);
    rx_byte = 8'h50; rx_valid = 1'b1; frame_active = 1'b0;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("abort_busy", busy, 0);
    @(posedge clk); #1;
    check("abort_no_we", mem_we, 0);
    check("abort_mem3", mem_img[3], 8'h40);
    frame_active = 1'b1;
    @(posedge clk); #1;
    end_test("abort");

    // Extra bytes after a completed burst start a new command
    fr = '{8'h01, 8'h20, 8'h01, 8'h5A, 8'h01, 8'h21, 8'h01, 8'h5B};
    model_frame(fr);
    send_bytes(fr, 1'b1);
    wait_idle(10);
    @(posedge clk); #1;
    check("extra_mem33", mem_img[33], 8'h5B);
    end_test("extra");
    frame_end();

    // Asynchronous reset during a read
    hs_count = 0;
    fr = '{8'h02, 8'h0A, 8'h05};
    model_frame(fr);
    send_bytes(fr, 1'b1);
    check("rst_rd_valid_pre", tx_valid, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("rst_rd_tx_valid", tx_valid, 0);
    check("rst_rd_busy", busy, 0);
    check("rst_rd_tx_byte", tx_byte, 0);
    check("rst_rd_we", mem_we, 0);
    exp_rd.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_rd_hs", hs_count, 0);
    end_test("reset_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Frame decoder sitting between the SPI byte receiver and the 101-byte parameter memory. It turns a framed byte stream into write-port transactions (`mem_addr`/`mem_data`/`mem_we`) with auto-incrementing address. It also serves burst readback of the memory's flattened contents bus back toward the SPI transmitter over a valid/ready handshake. It is the host-side writer/reader for the parameter store holding the SNN weights, thresholds and config bytes.

## Interface
- `DEPTH`, 101 — number of memory bytes; legal addresses 0..DEPTH-1.
- `ADDR_W`, 7 — address width.
- `clk` in 1 — clock.
- `reset` in 1 — asynchronous, active-high.
- `rx_byte` in 8 — received byte from SPI slave.
- `rx_valid` in 1 — one-cycle strobe, `rx_byte` valid.
- `frame_active` in 1 — high while chip-select is asserted; low aborts the frame.
- `mem_bus` in DEPTH*8 — flattened memory contents; byte k is at [k*8 +: 8].
- `mem_addr` out ADDR_W — write address to memory.
- `mem_data` out 8 — write data to memory.
- `mem_we` out 1 — write enable, one-cycle pulse per byte.
- `tx_byte` out 8 — readback byte toward SPI transmitter.
- `tx_valid` out 1 — `tx_byte` valid; held until accepted.
- `tx_ready` in 1 — transmitter accepts `tx_byte` when `tx_valid` and `tx_ready` are both high.
- `busy` out 1 — high in any state other than IDLE.
- `err` out 1 — sticky range/command error flag.

## Operation
- Frame format: CMD, START, LEN, then payload.
  - CMD: 0x01 = write burst, 0x02 = read burst.
  - START: bit 7 ignored, bits [6:0] are the start address.
  - LEN: 8-bit byte count.
- States:
  - IDLE: on `rx_valid`:
    - CMD 0x01 or 0x02 → GET_ADDR; latch the command; clear `err`.
    - Any other CMD → set `err`, go to DRAIN.
  - GET_ADDR: on `rx_valid`, latch `addr` = `rx_byte[6:0]` → GET_LEN.
  - GET_LEN: on `rx_valid`, latch `cnt` = `rx_byte`, then:
    - LEN = 0 → IDLE (no-op, no error).
    - START+LEN > DEPTH, computed 9-bit unsigned → set `err`, go to DRAIN.
    - Otherwise → WRITE (cmd 0x01) or READ (cmd 0x02).
  - WRITE: on each `rx_valid`:
    - Register `mem_addr` = `addr`, `mem_data` = `rx_byte`, pulse `mem_we`.
    - `addr`++, `cnt`--.
    - When `cnt` reaches 0 → IDLE.
  - READ:
    - `tx_byte` = `mem_bus[addr*8 +: 8]` (registered), `tx_valid` = 1.
    - On accept: `addr`++, `cnt`--, present the next byte; after the last accept → IDLE.
    - `rx_valid` bytes arriving in READ are ignored (full-duplex dummies).
  - DRAIN: ignore all bytes until `frame_active` goes low → IDLE.
- Abort: `frame_active` = 0 in any state forces IDLE next cycle.
  - `tx_valid` deasserts.
  - `cnt` and `addr` are discarded.
  - A pending `mem_we` is not issued.
  - `err` is unchanged.
- Extra bytes after a completed burst (IDLE with `frame_active` still high) are decoded as a new CMD.
- Writes never touch addresses ≥ DEPTH; the range check guarantees this.

## Timing
- Reset values:
  - State IDLE.
  - `mem_addr` = 0, `mem_data` = 0, `mem_we` = 0.
  - `tx_byte` = 0, `tx_valid` = 0.
  - `busy` = 0, `err` = 0.
- Write latency: `rx_valid` on payload byte at edge n → `mem_we` high for exactly cycle n+1; the memory captures it at edge n+2.
- Back-to-back `rx_valid` on consecutive cycles is supported: one `mem_we` per cycle with consecutive addresses.
- Read latency: the cycle after LEN is accepted, `tx_valid` = 1 with byte START.
  - If `tx_ready` is held high, one byte transfers per cycle.
  - `tx_byte` stays stable while `tx_valid` && !`tx_ready`.
- `busy` is a registered function of state (high the cycle after CMD is accepted).
- Simultaneous `rx_valid` and `frame_active` = 0: abort wins and the byte is dropped.
- Simultaneous last `tx` accept and `frame_active` = 0: the byte counts as transferred; state returns to IDLE either way.
- Reset mid-burst: all outputs return to reset values immediately; partially written bytes remain in memory.

## Test plan
- Write burst: CMD 01, START 05, LEN 03, data AA BB CC → `mem_we` pulses at addrs 5, 6, 7 with AA, BB, CC; `busy` falls after the third pulse; `err` = 0.
- Read burst with backpressure: `mem_bus` bytes 99..100 = 11, 22; CMD 02, START 99, LEN 2; `tx_ready` low for 3 cycles → `tx_byte` = 11 held stable, then 22; exactly 2 handshakes, then IDLE.
- Range error: CMD 01, START 100, LEN 2 → `err` = 1, no `mem_we`, remaining bytes ignored until `frame_active` falls; next valid CMD clears `err`.
- Bad command 0x7F → `err` = 1, DRAIN; following byte 01 is not decoded until after a `frame_active` low pulse.
- Abort: CMD 01, START 0, LEN 10, 4 data bytes, then `frame_active` low → exactly 4 writes (addrs 0..3), IDLE, `busy` = 0.
- LEN 0 no-op, and async `reset` asserted during a READ → `tx_valid` = 0 and `busy` = 0 immediately; no writes issued.
